pwm_duty_ramp: RTL

// - Upstream duty-cycle source for the PWM generator. Drives its 7-bit dc (0..100 %) input.
// - Slews dc from its current value toward a loaded target in fixed steps, at a programmable

---
 rtl/pwm_duty_ramp.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp
//   Upstream duty-cycle source for the PWM generator. Slews the 7-bit duty
//   output from its current value toward a loaded target, one STEP per tick,
//   so the PWM output gets a soft-start and a soft-stop.
//
// Parameters
//   DC_W    width of target/dc
//   DC_MAX  ceiling for dc; larger targets are clamped to this value
//   STEP    dc change per tick (1..DC_MAX)
//   RATE_W  width of rate; tick interval = (rate+1)*256 clocks
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous reset, active low
//   ena     in   global enable; low freezes all state and masks load
//   estop   in   (only with PWM_DUTY_RAMP_ESTOP_EN) synchronous emergency stop
//   target  in   requested duty, percent
//   load    in   1-cycle strobe; captures target and rate
//   rate    in   tick interval select
//   dc      out  current duty to the PWM generator (registered)
//   busy    out  high while ramping (state UP or DOWN)
//   done    out  1-cycle pulse when dc reaches the target
//   state   out  0=IDLE 1=UP 2=DOWN (debug)
//
// Configuration
//   PWM_DUTY_RAMP_ESTOP_EN  adds the estop input. While estop is high the
//   block is forced to IDLE with dc=0 and target=0, ignoring ena and load.
//
// Handshake: load is a single-cycle strobe qualified by ena; there is no
// back-pressure, a load is always accepted and retargets immediately.
module pwm_duty_ramp #(
    parameter int DC_W   = 7,
    parameter int DC_MAX = 100,
    parameter int STEP   = 1,
    parameter int RATE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
`ifdef PWM_DUTY_RAMP_ESTOP_EN
    input  logic              estop,
`endif
    input  logic [DC_W-1:0]   target,
    input  logic              load,
    input  logic [RATE_W-1:0] rate,
    output logic [DC_W-1:0]   dc,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    // Counter spans rate_q+1 PWM periods of 256 clocks.
    localparam int CNT_W = RATE_W + 8;
    localparam logic [DC_W-1:0] DC_MAX_V = DC_W'(DC_MAX);
    localparam logic [DC_W-1:0] STEP_V   = DC_W'(STEP);

    state_t              state_q, state_d;
    logic [DC_W-1:0]     dc_q, dc_d;
    logic [DC_W-1:0]     tgt_q, tgt_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;

    logic [DC_W-1:0]     tgt_new;
    logic [CNT_W-1:0]    term;
    logic                tick;
    logic                estop_i;

`ifdef PWM_DUTY_RAMP_ESTOP_EN
    assign estop_i = estop;
`else
    assign estop_i = 1'b0;
`endif

    assign tgt_new = (target > DC_MAX_V) ? DC_MAX_V : target;
    // (rate_q+1)*256 - 1 == {rate_q, 8'hFF}
    assign term    = {rate_q, 8'hFF};
    assign tick    = (state_q != IDLE) && (cnt_q == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dc_q    <= '0;
            tgt_q   <= '0;
            rate_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dc_q    <= dc_d;
            tgt_q   <= tgt_d;
            rate_q  <= rate_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dc_d    = dc_q;
        tgt_d   = tgt_q;
        rate_d  = rate_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (estop_i) begin
            state_d = IDLE;
            dc_d    = '0;
            tgt_d   = '0;
            cnt_d   = '0;
        end else if (!ena) begin
            // hold everything; done already defaults low
        end else if (load) begin
            // A tick landing in the same cycle is dropped: load restarts the interval.
            tgt_d  = tgt_new;
            rate_d = rate;
            cnt_d  = '0;
            if (tgt_new > dc_q) begin
                state_d = UP;
            end else if (tgt_new < dc_q) begin
                state_d = DOWN;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (state_q != IDLE) begin
            if (tick) begin
                cnt_d = '0;
                if (state_q == UP) begin
                    if ((tgt_q <= dc_q) || (tgt_q - dc_q <= STEP_V)) begin
                        dc_d    = tgt_q;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        dc_d = dc_q + STEP_V;
                    end
                end else begin
                    if ((dc_q <= tgt_q) || (dc_q - tgt_q <= STEP_V)) begin
                        dc_d    = tgt_q;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        dc_d = dc_q - STEP_V;
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign dc    = dc_q;
    assign done  = done_q;
    assign busy  = (state_q != IDLE);
    assign state = state_q;

endmodule
